// File: rtl/conv1d_tiler.sv
// rtl/conv1d_tiler.sv - tile sequencer feeding the conv1d engine from word memories
module conv1d_tiler #(
  parameter int AW = 16,
  parameter int TW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [TW-1:0] cfg_tiles_i,
  input  logic [AW-1:0] cfg_src_i,
  input  logic [AW-1:0] cfg_dst_i,
  input  logic [31:0]   cfg_k0_i,
  input  logic [31:0]   cfg_k1_i,
  input  logic [7:0]    cfg_bias_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          src_req_o,
  output logic [AW-1:0] src_addr_o,
  input  logic          src_ack_i,
  input  logic [31:0]   src_rdata_i,
  output logic          dst_req_o,
  output logic [AW-1:0] dst_addr_o,
  output logic [31:0]   dst_wdata_o,
  input  logic          dst_ack_i,
  output logic [6:0]    eng_cmd_o,
  output logic [31:0]   eng_inp0_o,
  output logic [31:0]   eng_inp1_o,
  input  logic [31:0]   eng_ret_i,
  input  logic          eng_valid_i
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_KLOAD   = 4'd1;
  localparam logic [3:0] S_FETCH   = 4'd2;
  localparam logic [3:0] S_WRITE   = 4'd3;
  localparam logic [3:0] S_START   = 4'd4;
  localparam logic [3:0] S_WAIT_LO = 4'd5;
  localparam logic [3:0] S_WAIT_HI = 4'd6;
  localparam logic [3:0] S_READ    = 4'd7;
  localparam logic [3:0] S_STORE   = 4'd8;
  localparam logic [3:0] S_NEXT    = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       last_q, last_d;
  logic [TW-1:0]    tile_q, tile_d;
  logic [TW-1:0]    tiles_q, tiles_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [31:0]      k0_q, k0_d;
  logic [31:0]      k1_q, k1_d;
  logic [7:0]       bias_q, bias_d;
  logic [3:0][31:0] win_q, win_d;
  logic [1:0][31:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             src_req_q, src_req_d;
  logic [AW-1:0]    src_addr_q, src_addr_d;
  logic             dst_req_q, dst_req_d;
  logic [AW-1:0]    dst_addr_q, dst_addr_d;
  logic [31:0]      dst_wdata_q, dst_wdata_d;
  logic [6:0]       eng_cmd_q, eng_cmd_d;
  logic [31:0]      eng_inp0_q, eng_inp0_d;
  logic [31:0]      eng_inp1_q, eng_inp1_d;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign src_req_o   = src_req_q;
  assign src_addr_o  = src_addr_q;
  assign dst_req_o   = dst_req_q;
  assign dst_addr_o  = dst_addr_q;
  assign dst_wdata_o = dst_wdata_q;
  assign eng_cmd_o   = eng_cmd_q;
  assign eng_inp0_o  = eng_inp0_q;
  assign eng_inp1_o  = eng_inp1_q;

  // Next-state logic; engine command defaults to 0 so nothing is held past its cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    last_d      = last_q;
    tile_d      = tile_q;
    tiles_d     = tiles_q;
    base_d      = base_q;
    src_d       = src_q;
    dst_d       = dst_q;
    k0_d        = k0_q;
    k1_d        = k1_q;
    bias_d      = bias_q;
    win_d       = win_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    src_req_d   = src_req_q;
    src_addr_d  = src_addr_q;
    dst_req_d   = dst_req_q;
    dst_addr_d  = dst_addr_q;
    dst_wdata_d = dst_wdata_q;
    eng_cmd_d   = 7'd0;
    eng_inp0_d  = 32'd0;
    eng_inp1_d  = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (start_i && eng_valid_i) begin
          tiles_d = cfg_tiles_i;
          src_d   = cfg_src_i;
          dst_d   = cfg_dst_i;
          k0_d    = cfg_k0_i;
          k1_d    = cfg_k1_i;
          bias_d  = cfg_bias_i;
          tile_d  = '0;
          base_d  = '0;
          win_d   = '0;
          cnt_d   = 2'd0;
          if (cfg_tiles_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_KLOAD;
            busy_d  = 1'b1;
          end
        end
      end
      S_KLOAD: begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: begin eng_cmd_d = 7'd2; eng_inp0_d = 32'd0; eng_inp1_d = k0_q; end
          2'd1: begin eng_cmd_d = 7'd2; eng_inp0_d = 32'd1; eng_inp1_d = k1_q; end
          default: begin
            eng_cmd_d  = 7'd8;
            eng_inp0_d = {24'd0, bias_q};
            state_d    = S_FETCH;
            // First tile: slot 0 is the left halo, slot 3 is right halo when only one tile.
            slot_d     = 2'd1;
            last_d     = (tiles_q == TW'(1)) ? 2'd2 : 2'd3;
          end
        endcase
      end
      S_FETCH: begin
        if (!src_req_q) begin
          src_req_d  = 1'b1;
          src_addr_d = src_q + base_q + AW'(slot_q) - AW'(1);
        end else if (src_ack_i) begin
          win_d[slot_q] = src_rdata_i;
          if (slot_q == last_q) begin
            src_req_d = 1'b0;
            state_d   = S_WRITE;
            cnt_d     = 2'd0;
          end else begin
            slot_d     = slot_q + 2'd1;
            src_addr_d = src_addr_q + AW'(1);
          end
        end
      end
      S_WRITE: begin
        eng_cmd_d  = 7'd1;
        eng_inp0_d = {30'd0, cnt_q};
        eng_inp1_d = win_q[cnt_q];
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_START;
      end
      S_START: begin
        eng_cmd_d = 7'd5;
        state_d   = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!eng_valid_i) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (eng_valid_i) begin
          state_d = S_READ;
          cnt_d   = 2'd0;
        end
      end
      S_READ: begin
        // Two read commands, each result lands two cycles after it is issued.
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: begin eng_cmd_d = 7'd3; eng_inp0_d = 32'd0; end
          2'd1: begin eng_cmd_d = 7'd3; eng_inp0_d = 32'd1; end
          2'd2: out_d[0] = eng_ret_i;
          default: begin
            out_d[1] = eng_ret_i;
            state_d  = S_STORE;
            slot_d   = 2'd0;
          end
        endcase
      end
      S_STORE: begin
        if (!dst_req_q) begin
          dst_req_d   = 1'b1;
          dst_addr_d  = dst_q + base_q + AW'(slot_q);
          dst_wdata_d = out_q[slot_q[0]];
        end else if (dst_ack_i) begin
          if (slot_q == 2'd0) begin
            slot_d      = 2'd1;
            dst_addr_d  = dst_addr_q + AW'(1);
            dst_wdata_d = out_q[1];
          end else begin
            dst_req_d = 1'b0;
            state_d   = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        tile_d   = tile_q + TW'(1);
        base_d   = base_q + AW'(2);
        // Upper half of this window is the lower half of the next one.
        win_d[0] = win_q[2];
        win_d[1] = win_q[3];
        win_d[2] = 32'd0;
        win_d[3] = 32'd0;
        if (tile_q + TW'(1) == tiles_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
          slot_d  = 2'd2;
          last_d  = (tile_q + TW'(2) == tiles_q) ? 2'd2 : 2'd3;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      last_q      <= '0;
      tile_q      <= '0;
      tiles_q     <= '0;
      base_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      k0_q        <= '0;
      k1_q        <= '0;
      bias_q      <= '0;
      win_q       <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      src_req_q   <= 1'b0;
      src_addr_q  <= '0;
      dst_req_q   <= 1'b0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
      eng_cmd_q   <= '0;
      eng_inp0_q  <= '0;
      eng_inp1_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      last_q      <= last_d;
      tile_q      <= tile_d;
      tiles_q     <= tiles_d;
      base_q      <= base_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      bias_q      <= bias_d;
      win_q       <= win_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      src_req_q   <= src_req_d;
      src_addr_q  <= src_addr_d;
      dst_req_q   <= dst_req_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
      eng_cmd_q   <= eng_cmd_d;
      eng_inp0_q  <= eng_inp0_d;
      eng_inp1_q  <= eng_inp1_d;
    end
  end

endmodule

// File: tb/tb_conv1d_tiler.sv
// tb/tb_conv1d_tiler.sv - self-checking bench for conv1d_tiler with engine and memory models
module tb_conv1d_tiler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_tiles, cfg_src, cfg_dst;
  logic [31:0] cfg_k0, cfg_k1;
  logic [7:0]  cfg_bias;
  logic        busy_o, done_o;
  logic        src_req_o, dst_req_o;
  logic [15:0] src_addr_o, dst_addr_o;
  logic [31:0] dst_wdata_o;
  logic        src_ack = 1'b0, dst_ack = 1'b0;
  logic [31:0] src_rdata = '0;
  logic [6:0]  eng_cmd_o;
  logic [31:0] eng_inp0_o, eng_inp1_o;
  logic [31:0] eng_ret = '0;
  logic        eng_valid = 1'b1;

  int tests = 0, fails = 0;
  int max_dly = 0, eng_lat = 4;
  int src_wait = 0, dst_wait = 0;
  int src_reads = 0, dst_writes = 0, done_cnt = 0, eng_cmds = 0, bad_cmd = 0;
  int src_hits[256];
  logic [31:0] src_mem[256];
  logic [31:0] dst_mem[256];

  conv1d_tiler #(.AW(16), .TW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .cfg_tiles_i(cfg_tiles), .cfg_src_i(cfg_src), .cfg_dst_i(cfg_dst),
    .cfg_k0_i(cfg_k0), .cfg_k1_i(cfg_k1), .cfg_bias_i(cfg_bias),
    .busy_o(busy_o), .done_o(done_o),
    .src_req_o(src_req_o), .src_addr_o(src_addr_o), .src_ack_i(src_ack), .src_rdata_i(src_rdata),
    .dst_req_o(dst_req_o), .dst_addr_o(dst_addr_o), .dst_wdata_o(dst_wdata_o), .dst_ack_i(dst_ack),
    .eng_cmd_o(eng_cmd_o), .eng_inp0_o(eng_inp0_o), .eng_inp1_o(eng_inp1_o),
    .eng_ret_i(eng_ret), .eng_valid_i(eng_valid)
  );

  always #5 clk = ~clk;

  // Source memory: ack after a random wait, data presented with the ack.
  always @(negedge clk) begin
    if (src_req_o && src_wait == 0) begin
      src_ack   = 1'b1;
      src_rdata = src_mem[src_addr_o[7:0]];
      src_reads++;
      src_hits[src_addr_o[7:0]]++;
      src_wait  = int'($urandom_range(max_dly, 0));
    end else begin
      src_ack = 1'b0;
      if (src_req_o && src_wait > 0) src_wait--;
    end
  end

  // Destination memory with the same random-wait behaviour.
  always @(negedge clk) begin
    if (dst_req_o && dst_wait == 0) begin
      dst_ack = 1'b1;
      dst_mem[dst_addr_o[7:0]] = dst_wdata_o;
      dst_writes++;
      dst_wait = int'($urandom_range(max_dly, 0));
    end else begin
      dst_ack = 1'b0;
      if (dst_req_o && dst_wait > 0) dst_wait--;
    end
  end

  always @(negedge clk) if (done_o) done_cnt++;

  // Behavioural conv1d engine: 8 taps over a 16-byte window, 8 output bytes.
  logic [7:0] kb[8];
  logic [7:0] ib[16];
  logic [7:0] ob[8];
  logic [7:0] ebias = '0;
  int ecnt = 0;
  always @(posedge clk) begin
    if (eng_cmd_o != 7'd0) eng_cmds++;
    if (eng_valid) begin
      case (eng_cmd_o)
        7'd0: ;
        7'd1: for (int b = 0; b < 4; b++) ib[int'(eng_inp0_o[1:0]) * 4 + b] = eng_inp1_o[31 - 8 * b -: 8];
        7'd2: for (int b = 0; b < 4; b++) kb[int'(eng_inp0_o[0]) * 4 + b] = eng_inp1_o[31 - 8 * b -: 8];
        7'd8: ebias = eng_inp0_o[7:0];
        7'd5: begin eng_valid <= 1'b0; ecnt = eng_lat; end
        7'd3: eng_ret <= {ob[int'(eng_inp0_o[0]) * 4], ob[int'(eng_inp0_o[0]) * 4 + 1],
                          ob[int'(eng_inp0_o[0]) * 4 + 2], ob[int'(eng_inp0_o[0]) * 4 + 3]};
        default: bad_cmd++;
      endcase
    end else begin
      if (eng_cmd_o != 7'd0) bad_cmd++;
      if (ecnt > 1) ecnt--;
      else begin
        for (int j = 0; j < 8; j++) begin
          int s;
          s = int'(ebias);
          for (int t = 0; t < 8; t++) s += int'(kb[t]) * int'(ib[j + t]);
          ob[j] = 8'(s);
        end
        eng_valid <= 1'b1;
      end
    end
  end

  // Reference: whole-signal convolution with zeros outside [0, 8n).
  function automatic logic [7:0] samp(int base, int n, int i);
    logic [31:0] w;
    if (i < 0 || i >= 8 * n) return 8'd0;
    w = src_mem[base + i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  function automatic logic [31:0] ref_word(int base, int n, logic [31:0] k0, logic [31:0] k1,
                                           logic [7:0] b, int m);
    logic [31:0] r;
    logic [63:0] k;
    k = {k0, k1};
    for (int bb = 0; bb < 4; bb++) begin
      int s;
      s = int'(b);
      for (int t = 0; t < 8; t++) s += int'(k[63 - 8 * t -: 8]) * int'(samp(base, n, 4 * m + bb + t - 4));
      r[31 - 8 * bb -: 8] = 8'(s);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int n, input int sb, input int db, input logic [31:0] k0,
                         input logic [31:0] k1, input logic [7:0] b, input int dly, input bit disturb);
    int r0, w0, d0, e0, c, once;
    int h0[256];
    max_dly = dly;
    cfg_tiles = 16'(n); cfg_src = 16'(sb); cfg_dst = 16'(db);
    cfg_k0 = k0; cfg_k1 = k1; cfg_bias = b;
    r0 = src_reads; w0 = dst_writes; d0 = done_cnt; e0 = eng_cmds; h0 = src_hits;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (done_cnt == d0 && c < 4000) begin
      @(posedge clk); #1;
      start = disturb && c == 20;
      if (disturb && c == 20) begin
        chk("busy_at_restart", 160'(busy_o), 160'(1));
        cfg_tiles = 16'd1; cfg_src = 16'd0; cfg_dst = 16'(db + 1);
        cfg_k0 = 32'hffffffff; cfg_k1 = 32'hffffffff; cfg_bias = 8'hff;
      end
      c++;
    end
    start = 1'b0;
    chk("job_timeout", 160'(c < 4000), 160'(1));
    repeat (30) @(posedge clk);
    #1;
    chk("busy_after", 160'(busy_o), 160'(0));
    chk("done_count", 160'(done_cnt - d0), 160'(1));
    chk("src_reads", 160'(src_reads - r0), 160'(2 * n));
    chk("dst_writes", 160'(dst_writes - w0), 160'(2 * n));
    chk("eng_cmds", 160'(eng_cmds - e0), 160'(n == 0 ? 0 : 3 + 7 * n));
    once = 0;
    for (int a = sb; a < sb + 2 * n; a++) if (src_hits[a] - h0[a] == 1) once++;
    chk("reads_once", 160'(once), 160'(2 * n));
    for (int m = 0; m < 2 * n; m++)
      chk("dst_model", 160'(dst_mem[db + m]), 160'(ref_word(sb, n, k0, k1, b, m)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sb, ab, w;
    logic [31:0] rk0, rk1;
    logic [7:0] rb;
    for (int a = 0; a < 256; a++) begin src_mem[a] = $urandom; src_hits[a] = 0; end
    src_mem[10] = 32'h01020304; src_mem[11] = 32'h05060708;
    for (int a = 20; a < 26; a++) src_mem[a] = {8'(4*(a-20)+1), 8'(4*(a-20)+2), 8'(4*(a-20)+3), 8'(4*(a-20)+4)};
    src_mem[40] = 32'h01010101; src_mem[41] = 32'h01010101;
    for (int a = 50; a < 54; a++) src_mem[a] = 32'h02020202;

    rst_n = 1'b0; start = 1'b0;
    cfg_tiles = '0; cfg_src = '0; cfg_dst = '0; cfg_k0 = '0; cfg_k1 = '0; cfg_bias = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 160'({busy_o, done_o, src_req_o, dst_req_o, eng_cmd_o, eng_inp0_o,
                               eng_inp1_o, src_addr_o, dst_addr_o, dst_wdata_o}), 160'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Identity kernel, one tile.
    run_job(1, 10, 60, 32'h0, 32'h01000000, 8'd0, 0, 1'b0);
    chk("identity_w0", 160'(dst_mem[60]), 160'(32'h01020304));
    chk("identity_w1", 160'(dst_mem[61]), 160'(32'h05060708));

    // All-ones kernel shows the zero halo on both sides.
    run_job(1, 40, 64, 32'h01010101, 32'h01010101, 8'd0, 0, 1'b0);
    chk("halo_w0", 160'(dst_mem[64]), 160'(32'h04050607));
    chk("halo_w1", 160'(dst_mem[65]), 160'(32'h08070605));

    // Tap0 only over three tiles: output is input shifted right by four samples.
    run_job(3, 20, 70, 32'h01000000, 32'h0, 8'd0, 0, 1'b0);
    chk("multi_w0", 160'(dst_mem[70]), 160'(32'h00000000));
    chk("multi_w1", 160'(dst_mem[71]), 160'(32'h01020304));
    chk("multi_w5", 160'(dst_mem[75]), 160'(32'h11121314));

    // 127*2+5 wraps to 3.
    run_job(2, 50, 80, 32'h0, 32'h7f000000, 8'd5, 0, 1'b0);
    for (int m = 0; m < 4; m++) chk("wrap_bias", 160'(dst_mem[80 + m]), 160'(32'h03030303));

    // Zero tiles: done only.
    run_job(0, 0, 90, 32'h0, 32'h0, 8'd0, 0, 1'b0);

    // Random jobs: zero-wait, then backpressure with a start pulse while busy.
    for (int i = 0; i < 3; i++) begin
      n = int'($urandom_range(6, 2)); sb = int'($urandom_range(140, 60));
      rk0 = $urandom; rk1 = $urandom; rb = 8'($urandom);
      ab = 130 + 40 * i;
      eng_lat = int'($urandom_range(6, 1));
      run_job(n, sb, ab, rk0, rk1, rb, 0, 1'b0);
      run_job(n, sb, ab + 16, rk0, rk1, rb, 5, 1'b1);
      for (int m = 0; m < 2 * n; m++) chk("bp_equal", 160'(dst_mem[ab + 16 + m]), 160'(dst_mem[ab + m]));
    end

    // Reset while the tiler waits for the engine result.
    max_dly = 0; eng_lat = 40;
    cfg_tiles = 16'd1; cfg_src = 16'd10; cfg_dst = 16'd100;
    cfg_k0 = 32'h0; cfg_k1 = 32'h01000000; cfg_bias = 8'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (eng_valid && w < 200) begin @(posedge clk); #1; w++; end
    chk("reach_wait_hi", 160'(w < 200), 160'(1));
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("reset_midjob", 160'({busy_o, done_o, src_req_o, dst_req_o, eng_cmd_o, eng_inp0_o,
                              eng_inp1_o, src_addr_o, dst_addr_o, dst_wdata_o}), 160'(0));
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_refused", 160'({eng_valid, busy_o, src_req_o}), 160'(0));
    w = 0;
    while (!eng_valid && w < 200) begin @(posedge clk); #1; w++; end
    chk("engine_ready", 160'(w < 200), 160'(1));
    eng_lat = 4;
    run_job(1, 10, 104, 32'h0, 32'h01000000, 8'd0, 0, 1'b0);
    chk("post_reset_w0", 160'(dst_mem[104]), 160'(32'h01020304));
    chk("post_reset_w1", 160'(dst_mem[105]), 160'(32'h05060708));

    chk("engine_protocol", 160'(bad_cmd), 160'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
